keypad_word_controller: RTL
===========================

Name: keypad_word_controller

Overview:
- Front-end sequencer between the raw keypad lines and the word-length counter / letter buffer.
- Synchronises and debounces key and star inputs, and turns each clean press into exactly one action:
  - letter key: writes the key code into the letter buffer and advances the word length.
  - star key: commits the word (length plus valid pulse) and clears the length.
- Replaces the scheme that used the keypad line directly as a clock: everything here runs on the system clock.

Parameters:
- KEY_W, 4, width of key_code / letter_data.
- MAX_LEN, 7, maximum letters per word; must not exceed 2**LEN_W-1.
- LEN_W, 3, width of the length and address outputs.
- DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a press or a release (N below).
- DB_CNT_W, 8, width of the debounce counter; must hold N.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state on the next posedge.
- key_pressed  in  1  raw, asynchronous letter-key press level.
- is_star_pressed  in  1  raw, asynchronous star-key press level.
- key_code  in  KEY_W  raw code of the pressed letter key; valid while key_pressed is high.
- letter_we  out  1  one-cycle write strobe to the letter buffer.
- letter_addr  out  LEN_W  buffer address, equal to the word length before the write.
- letter_data  out  KEY_W  latched key code.
- word_len  out  LEN_W  current letter count.
- word_valid  out  1  one-cycle commit pulse.
- word_len_out  out  LEN_W  committed length; held until the next commit.
- overflow  out  1  sticky flag: a letter was dropped because the word was full.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset value of every output and register is 0; FSM returns to IDLE.
- Reset mid-press discards the in-flight press; no strobe is issued for it.
- Synchroniser: key_pressed, is_star_pressed and key_code each pass through a 2-flop synchroniser. The combined request is raw_s = key_s | star_s.
- FSM states: IDLE, PRESS_DB, ACCEPT, HOLD, RELEASE_DB.
- IDLE: when raw_s = 1, go to PRESS_DB with db_cnt = 1.
- PRESS_DB:
  - raw_s = 1: db_cnt++; when db_cnt = N, latch star_s and key_code_s, then go to ACCEPT.
  - raw_s = 0: return to IDLE (bounce rejected, no action).
- ACCEPT (one cycle; all outputs registered, so strobes appear the cycle after ACCEPT):
  - Star latched, word_len > 0: word_valid = 1, word_len_out <= word_len, word_len <= 0, overflow <= 0.
  - Star latched, word_len = 0: no word_valid; overflow <= 0.
  - Letter, word_len < MAX_LEN: letter_we = 1, letter_addr = word_len, letter_data = code, word_len++.
  - Letter, word_len = MAX_LEN: no write, word_len unchanged, overflow <= 1.
  - Always go to HOLD next.
- HOLD: stay while raw_s = 1; when raw_s = 0, go to RELEASE_DB with db_cnt = 1.
- RELEASE_DB:
  - raw_s = 0: db_cnt++; when db_cnt = N, go to IDLE.
  - raw_s = 1: return to HOLD.
  - Consequence: a held key never repeats.
- Simultaneous letter and star at accept: star wins and the letter is ignored.
- Latency: letter_we / word_valid rise exactly N+3 posedges after the first posedge that samples the raw input high (2 synchroniser + N debounce + 1 registered output); with N = 4 that is 7 cycles.
- Pulse widths: letter_we and word_valid are exactly one cycle wide, and are never asserted together.
- Arithmetic: word_len is unsigned, saturates at MAX_LEN, never wraps.

Decomposition:
- Package keypad_pkg:
  - FSM state enum.
  - Default constants KEY_W, LEN_W, MAX_LEN.
  - STAR_ACTION / LETTER_ACTION encoding.
- Sub-module key_debouncer: synchroniser plus the press/release debounce FSM.
  - Outputs a one-cycle accept pulse plus the latched star flag and code.
  - Instantiated once; length, overflow and commit logic stay in the top.

Test Plan (all with N = 4):
1. Clean letter press: key_pressed = 1, key_code = 4'h5 for 20 cycles, then released for 10. Expected: letter_we high for one cycle at cycle 7, letter_addr = 0, letter_data = 5, word_len = 1, busy returns to 0.
2. Bounce rejection: key_pressed toggled high 2 cycles / low 2 cycles for 40 cycles. Expected: letter_we never asserted, word_len = 0; on release bounces after a valid press, exactly one write.
3. Word of 3 letters then star (codes 1, 2, 3): writes to addr 0, 1, 2; star gives word_valid for one cycle with word_len_out = 3 and word_len = 0 the cycle after.
4. Overflow: 8 letters pressed. Expected: 7 writes (addr 0–6), 8th dropped, overflow = 1, word_len = 7; a following star gives word_len_out = 7 and overflow = 0.
5. Empty star and simultaneous press:
   - Star with word_len = 0: no word_valid.
   - Letter and star asserted on the same cycle with word_len = 2: word_valid with word_len_out = 2, no letter_we.
6. Reset mid-press: reset pulsed 3 cycles into PRESS_DB, then key held. Expected: no strobe from the aborted press, all outputs 0 after reset, and a fresh press after release writes addr 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and default sizing for the keypad word controller slice.
package keypad_pkg;

  localparam int DEFAULT_KEY_W   = 4;
  localparam int DEFAULT_LEN_W   = 3;
  localparam int DEFAULT_MAX_LEN = 7;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    ACCEPT     = 3'd2,
    HOLD       = 3'd3,
    RELEASE_DB = 3'd4
  } kp_state_e;

  typedef enum logic {
    LETTER_ACTION = 1'b0,
    STAR_ACTION   = 1'b1
  } kp_action_e;

endpackage

// File: rtl/keypad_word_controller_if.sv
// Keypad lines in, letter-buffer and word-commit signals out.
interface keypad_word_controller_if
  import keypad_pkg::*;
#(
  parameter int KEY_W = DEFAULT_KEY_W,
  parameter int LEN_W = DEFAULT_LEN_W
);

  logic             key_pressed;
  logic             is_star_pressed;
  logic [KEY_W-1:0] key_code;
  logic             letter_we;
  logic [LEN_W-1:0] letter_addr;
  logic [KEY_W-1:0] letter_data;
  logic [LEN_W-1:0] word_len;
  logic             word_valid;
  logic [LEN_W-1:0] word_len_out;
  logic             overflow;
  logic             busy;

  // The controller side: consumes keypad lines, produces buffer/commit signals.
  modport master (
    input  key_pressed, is_star_pressed, key_code,
    output letter_we, letter_addr, letter_data,
    output word_len, word_valid, word_len_out, overflow, busy
  );

  modport slave (
    output key_pressed, is_star_pressed, key_code,
    input  letter_we, letter_addr, letter_data,
    input  word_len, word_valid, word_len_out, overflow, busy
  );

endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchronisers plus press/release debounce FSM; emits one accept
// pulse per clean press together with the latched action and key code.
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int KEY_W           = DEFAULT_KEY_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_pressed,
  input  logic             is_star_pressed,
  input  logic [KEY_W-1:0] key_code,
  output logic             accept,
  output kp_action_e       acc_action,
  output logic [KEY_W-1:0] acc_code,
  output logic             busy
);

  localparam logic [DB_CNT_W-1:0] DB_N   = DB_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_CNT_W-1:0] DB_ONE = DB_CNT_W'(1);

  logic             key_p0, key_p1;
  logic             star_p0, star_p1;
  logic [KEY_W-1:0] code_p0, code_p1;
  logic             raw_s;

  kp_state_e           state, state_nx;
  logic [DB_CNT_W-1:0] db_cnt, cnt_nx;
  logic                latch_en;

  // Stage p0 -> p1: metastability guard on every raw keypad line
  always_ff @(posedge clk) begin
    if (reset) begin
      key_p0  <= 1'b0;
      key_p1  <= 1'b0;
      star_p0 <= 1'b0;
      star_p1 <= 1'b0;
      code_p0 <= '0;
      code_p1 <= '0;
    end else begin
      key_p0  <= key_pressed;
      key_p1  <= key_p0;
      star_p0 <= is_star_pressed;
      star_p1 <= star_p0;
      code_p0 <= key_code;
      code_p1 <= code_p0;
    end
  end

  assign raw_s = key_p1 | star_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state  <= state_nx;
      db_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = db_cnt;
    unique case (state)
      IDLE: begin
        if (raw_s) begin
          state_nx = PRESS_DB;
          cnt_nx   = DB_ONE;
        end
      end
      PRESS_DB: begin
        if (!raw_s)               state_nx = IDLE;
        else if (db_cnt == DB_N)  state_nx = ACCEPT;
        else                      cnt_nx   = db_cnt + 1'b1;
      end
      ACCEPT: state_nx = HOLD;
      HOLD: begin
        if (!raw_s) begin
          state_nx = RELEASE_DB;
          cnt_nx   = DB_ONE;
        end
      end
      RELEASE_DB: begin
        // Any high sample goes back to HOLD, so a held key never repeats
        if (raw_s)                state_nx = HOLD;
        else if (db_cnt == DB_N)  state_nx = IDLE;
        else                      cnt_nx   = db_cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == ACCEPT);
    busy     = (state != IDLE);
    latch_en = (state == PRESS_DB) && raw_s && (db_cnt == DB_N);
  end

  // Star takes priority when both lines are high at the latch point
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_action <= LETTER_ACTION;
      acc_code   <= '0;
    end else if (latch_en) begin
      acc_action <= star_p1 ? STAR_ACTION : LETTER_ACTION;
      acc_code   <= code_p1;
    end
  end

endmodule

// File: rtl/keypad_word_controller.sv
// Keypad front end: debounced presses become letter writes or word commits,
// with a saturating word length and a sticky overflow flag.
module keypad_word_controller
  import keypad_pkg::*;
#(
  parameter int KEY_W           = DEFAULT_KEY_W,
  parameter int MAX_LEN         = DEFAULT_MAX_LEN,
  parameter int LEN_W           = DEFAULT_LEN_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_CNT_W        = 8
) (
  input logic clk,
  input logic reset,
  keypad_word_controller_if.master bus
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic             accept;
  kp_action_e       acc_action;
  logic [KEY_W-1:0] acc_code;
  logic             busy;

  logic             letter_we_p0;
  logic [LEN_W-1:0] letter_addr_p0;
  logic [KEY_W-1:0] letter_data_p0;
  logic [LEN_W-1:0] word_len;
  logic             word_valid_p0;
  logic [LEN_W-1:0] word_len_out;
  logic             overflow;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v >= MAX_LEN_L) ? v : v + 1'b1;
  endfunction

  key_debouncer #(
    .KEY_W           (KEY_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_CNT_W        (DB_CNT_W)
  ) u_debouncer (
    .clk             (clk),
    .reset           (reset),
    .key_pressed     (bus.key_pressed),
    .is_star_pressed (bus.is_star_pressed),
    .key_code        (bus.key_code),
    .accept          (accept),
    .acc_action      (acc_action),
    .acc_code        (acc_code),
    .busy            (busy)
  );

  // Stage p0: the accept cycle resolves into registered strobes and state
  always_ff @(posedge clk) begin
    if (reset) begin
      letter_we_p0   <= 1'b0;
      letter_addr_p0 <= '0;
      letter_data_p0 <= '0;
      word_len       <= '0;
      word_valid_p0  <= 1'b0;
      word_len_out   <= '0;
      overflow       <= 1'b0;
    end else begin
      letter_we_p0  <= 1'b0;
      word_valid_p0 <= 1'b0;
      if (accept) begin
        if (acc_action == STAR_ACTION) begin
          overflow <= 1'b0;
          if (word_len != '0) begin
            word_valid_p0 <= 1'b1;
            word_len_out  <= word_len;
            word_len      <= '0;
          end
        end else if (word_len < MAX_LEN_L) begin
          letter_we_p0   <= 1'b1;
          letter_addr_p0 <= word_len;
          letter_data_p0 <= acc_code;
          word_len       <= sat_inc(word_len);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign bus.letter_we    = letter_we_p0;
  assign bus.letter_addr  = letter_addr_p0;
  assign bus.letter_data  = letter_data_p0;
  assign bus.word_len     = word_len;
  assign bus.word_valid   = word_valid_p0;
  assign bus.word_len_out = word_len_out;
  assign bus.overflow     = overflow;
  assign bus.busy         = busy;

endmodule
